// File: rtl/redun_mont_pkg.sv
// Shared types and helpers for the redundant-form Montgomery squaring path:
// operand layout, sequencer state encoding and binary/redundant conversions.
package redun_mont_pkg;

  localparam int DAT_BITS       = 1024;
  localparam int WRD_BITS       = 16;
  localparam int NUM_WRDS       = DAT_BITS / WRD_BITS + 1;
  localparam int REDUN_WRD_BITS = WRD_BITS + 1;
  localparam int T_LEN          = 32;
  // Wide enough for any redundant array once all word carries are folded in.
  localparam int BIN_BITS       = (NUM_WRDS - 1) * WRD_BITS + REDUN_WRD_BITS + 1;

  typedef logic [NUM_WRDS-1:0][REDUN_WRD_BITS-1:0] redun0_t;

  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    SQ_CONV,
    SQ_DONE
  } sq_seq_state_t;

  function automatic redun0_t to_redun(input logic [DAT_BITS-1:0] dat);
    redun0_t r;
    r = '0;
    for (int i = 0; i < DAT_BITS / WRD_BITS; i++)
      r[i] = REDUN_WRD_BITS'(dat[i*WRD_BITS +: WRD_BITS]);
    return r;
  endfunction

  function automatic logic [BIN_BITS-1:0] from_redun(input redun0_t r);
    logic [BIN_BITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      acc = acc + (BIN_BITS'(r[i]) << (i * WRD_BITS));
    return acc;
  endfunction

endpackage

// File: rtl/redun_carry_prop.sv
// Word-serial carry propagation of a redundant word array into plain binary,
// one word per clock, started by a single-cycle pulse and ending in a done pulse.
module redun_carry_prop #(
  parameter int DAT_BITS = redun_mont_pkg::DAT_BITS,
  parameter int WRD_BITS = redun_mont_pkg::WRD_BITS,
  parameter int NUM_WRDS = redun_mont_pkg::NUM_WRDS,
  parameter int RED_BITS = redun_mont_pkg::REDUN_WRD_BITS
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [NUM_WRDS-1:0][RED_BITS-1:0] i_cap,
  output logic [DAT_BITS-1:0]               o_res,
  output logic                              o_ovf,
  output logic                              o_done
);

  localparam int CAR_BITS = RED_BITS - WRD_BITS + 1;
  localparam int SUM_BITS = RED_BITS + 1;
  localparam int ACC_BITS = NUM_WRDS * WRD_BITS;
  localparam int K_BITS   = $clog2(NUM_WRDS + 1);

  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, last;
  logic [K_BITS-1:0]   k_q, k_d, k_cur;
  logic [CAR_BITS-1:0] carry_q, carry_d, carry_in;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [RED_BITS-1:0] wrd;
  logic [SUM_BITS-1:0] sum;

  // The start cycle itself folds word 0 with a zero carry, so no cycle is lost.
  always_comb begin
    k_cur    = i_start ? '0 : k_q;
    carry_in = i_start ? '0 : carry_q;
    wrd      = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      if (k_cur == K_BITS'(i)) wrd = i_cap[i];
    sum      = SUM_BITS'(wrd) + SUM_BITS'(carry_in);
    last     = (k_cur == K_BITS'(NUM_WRDS - 1));
    busy_d   = busy_q;
    k_d      = k_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    if (i_start || busy_q) begin
      for (int i = 0; i < NUM_WRDS; i++)
        if (k_cur == K_BITS'(i)) acc_d[i*WRD_BITS +: WRD_BITS] = sum[WRD_BITS-1:0];
      carry_d = sum[SUM_BITS-1:WRD_BITS];
      k_d     = k_cur + K_BITS'(1);
      busy_d  = !last;
      done_d  = last;
      if (last) ovf_d = (|acc_d[ACC_BITS-1:DAT_BITS]) | (|carry_d);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      k_q    <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      k_q    <= k_d;
    end
  end

  always_ff @(posedge i_clk) begin
    carry_q <= carry_d;
    acc_q   <= acc_d;
    ovf_q   <= ovf_d;
  end

  assign o_res  = acc_q[DAT_BITS-1:0];
  assign o_ovf  = ovf_q;
  assign o_done = done_q;

endmodule

// File: rtl/redun_sq_seq.sv
// Job sequencer for the free-running redundant squaring core: launches one
// operand, captures the T-th square and converts it back to binary.
module redun_sq_seq #(
  parameter int DAT_BITS = redun_mont_pkg::DAT_BITS,
  parameter int WRD_BITS = redun_mont_pkg::WRD_BITS,
  parameter int NUM_WRDS = redun_mont_pkg::NUM_WRDS,
  parameter int RED_BITS = redun_mont_pkg::REDUN_WRD_BITS,
  parameter int T_LEN    = redun_mont_pkg::T_LEN
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start_val,
  input  logic [DAT_BITS-1:0]     i_start_dat,
  input  logic [T_LEN-1:0]        i_iter,
  output logic                    o_start_rdy,
  output redun_mont_pkg::redun0_t o_sq,
  output logic                    o_sq_val,
  input  redun_mont_pkg::redun0_t i_mul,
  input  logic                    i_mul_val,
  output logic [DAT_BITS-1:0]     o_res,
  output logic                    o_res_ovf,
  output logic                    o_res_val,
  input  logic                    i_res_rdy,
  output logic [T_LEN-1:0]        o_cnt
);
  import redun_mont_pkg::*;

  sq_seq_state_t       state_q, state_d;
  logic [T_LEN-1:0]    t_q, t_d, cnt_q, cnt_d, cnt_inc;
  redun0_t             sq_q, sq_d, cap_q, cap_d;
  logic                sq_val_q, sq_val_d, cp_start_q, cp_start_d;
  logic                res_ovf_q, res_ovf_d, res_val_q, res_val_d;
  logic [DAT_BITS-1:0] res_q, res_d, cp_res;
  logic                cp_ovf, cp_done;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    sq_d       = sq_q;
    sq_val_d   = 1'b0;
    cap_d      = cap_q;
    cp_start_d = 1'b0;
    res_d      = res_q;
    res_ovf_d  = res_ovf_q;
    res_val_d  = res_val_q;
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + T_LEN'(1);
    unique case (state_q)
      SQ_IDLE: if (i_start_val) begin
        t_d   = i_iter;
        cnt_d = '0;
        // T=0 skips the core entirely: the start value itself is the result.
        if (i_iter != '0) begin
          sq_d     = to_redun(i_start_dat);
          sq_val_d = 1'b1;
          state_d  = SQ_ISSUE;
        end else begin
          cap_d      = to_redun(i_start_dat);
          cp_start_d = 1'b1;
          state_d    = SQ_CONV;
        end
      end
      SQ_ISSUE: begin
        sq_d    = '0;
        state_d = SQ_WAIT;
      end
      SQ_WAIT: if (i_mul_val) begin
        cnt_d = cnt_inc;
        if (cnt_inc == t_q) begin
          cap_d      = i_mul;
          cp_start_d = 1'b1;
          state_d    = SQ_CONV;
        end
      end
      SQ_CONV: if (cp_done) begin
        res_d     = cp_res;
        res_ovf_d = cp_ovf;
        res_val_d = 1'b1;
        state_d   = SQ_DONE;
      end
      SQ_DONE: if (i_res_rdy) begin
        res_val_d = 1'b0;
        state_d   = SQ_IDLE;
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= SQ_IDLE;
      t_q        <= '0;
      cnt_q      <= '0;
      sq_q       <= '0;
      sq_val_q   <= 1'b0;
      cp_start_q <= 1'b0;
      res_q      <= '0;
      res_ovf_q  <= 1'b0;
      res_val_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      sq_q       <= sq_d;
      sq_val_q   <= sq_val_d;
      cp_start_q <= cp_start_d;
      res_q      <= res_d;
      res_ovf_q  <= res_ovf_d;
      res_val_q  <= res_val_d;
    end
  end

  always_ff @(posedge i_clk) begin
    cap_q <= cap_d;
  end

  redun_carry_prop #(
    .DAT_BITS(DAT_BITS),
    .WRD_BITS(WRD_BITS),
    .NUM_WRDS(NUM_WRDS),
    .RED_BITS(RED_BITS)
  ) u_carry_prop (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(cp_start_q),
    .i_cap  (cap_q),
    .o_res  (cp_res),
    .o_ovf  (cp_ovf),
    .o_done (cp_done)
  );

  assign o_start_rdy = (state_q == SQ_IDLE);
  assign o_sq        = sq_q;
  assign o_sq_val    = sq_val_q;
  assign o_res       = res_q;
  assign o_res_ovf   = res_ovf_q;
  assign o_res_val   = res_val_q;
  assign o_cnt       = cnt_q;

endmodule
